// File: rtl/word_to_byte_serializer.sv
// Streams a 32-bit word out one byte per accepted cycle, low-order bytes selected by in_len.
// A new word may load on the final-byte handshake, so back-to-back words sustain 1 byte/cycle.
module word_to_byte_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_word,
    input  logic [1:0]  in_len,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  len_q, len_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  idx;
    logic        at_last;
    logic        accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign at_last = (cnt_q == len_q);
    assign accept  = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    word_d  = in_word;
                    len_d   = in_len;
                    cnt_d   = 2'd0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (!at_last) begin
                        cnt_d = cnt_q + 2'd1;
                    end else if (accept) begin
                        word_d = in_word;
                        len_d  = in_len;
                        cnt_d  = 2'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registers, except in_ready which may chain off out_ready.
    always_comb begin
        out_valid = (state_q == SEND);
        busy      = out_valid;
        out_last  = out_valid & at_last;
        idx       = MSB_FIRST ? (len_q - cnt_q) : cnt_q;
        out_byte  = out_valid ? word_q[{idx, 3'b000} +: 8] : 8'h00;
        in_ready  = rst_n & ((state_q == IDLE) | (out_valid & out_ready & out_last));
    end

endmodule

// File: tb/tb_word_to_byte_serializer.sv
// Directed bench for word_to_byte_serializer in both byte orders.
module tb_word_to_byte_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_word;
    logic [1:0]  in_len;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready0, in_ready1;
    logic [7:0]  out_byte0, out_byte1;
    logic        out_valid0, out_valid1;
    logic        out_last0, out_last1;
    logic        busy0, busy1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    word_to_byte_serializer #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_len(in_len),
        .in_valid(in_valid), .in_ready(in_ready0), .out_byte(out_byte0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_last(out_last0),
        .busy(busy0)
    );

    word_to_byte_serializer #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_len(in_len),
        .in_valid(in_valid), .in_ready(in_ready1), .out_byte(out_byte1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_last(out_last1),
        .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic byte0(input string tag, input logic [7:0] b, input logic last,
                         input logic rdy);
        chk({tag, "_valid"}, 32'(out_valid0), 32'd1);
        chk({tag, "_byte"}, 32'(out_byte0), 32'(b));
        chk({tag, "_last"}, 32'(out_last0), 32'(last));
        chk({tag, "_in_ready"}, 32'(in_ready0), 32'(rdy));
    endtask

    task automatic byte1(input string tag, input logic [7:0] b, input logic last);
        chk({tag, "_valid"}, 32'(out_valid1), 32'd1);
        chk({tag, "_byte"}, 32'(out_byte1), 32'(b));
        chk({tag, "_last"}, 32'(out_last1), 32'(last));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_word   = 32'h0;
        in_len    = 2'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_out_byte", 32'(out_byte0), 32'h00);
        chk("rst_out_last", 32'(out_last0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_in_ready", 32'(in_ready0), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready0), 32'd1);

        // single 4-byte word, LSB first
        in_word  = 32'hDDCCBBAA;
        in_len   = 2'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        byte0("w1_b0", 8'hAA, 1'b0, 1'b0);
        tick();
        byte0("w1_b1", 8'hBB, 1'b0, 1'b0);
        tick();
        byte0("w1_b2", 8'hCC, 1'b0, 1'b0);
        tick();
        byte0("w1_b3", 8'hDD, 1'b1, 1'b1);
        tick();
        chk("w1_idle_valid", 32'(out_valid0), 32'd0);

        // back-to-back; second word held valid from the first byte on
        in_word  = 32'h44332211;
        in_len   = 2'd3;
        in_valid = 1'b1;
        tick();
        in_word  = 32'h000000EE;
        in_len   = 2'd0;
        byte0("b2b_b0", 8'h11, 1'b0, 1'b0);
        tick();
        byte0("b2b_b1", 8'h22, 1'b0, 1'b0);
        tick();
        byte0("b2b_b2", 8'h33, 1'b0, 1'b0);
        tick();
        byte0("b2b_b3", 8'h44, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        byte0("b2b_ee", 8'hEE, 1'b1, 1'b1);
        tick();
        chk("b2b_idle_valid", 32'(out_valid0), 32'd0);
        chk("b2b_idle_busy", 32'(busy0), 32'd0);

        // backpressure: out_ready 1,0,0,1
        in_word  = 32'h0000BEEF;
        in_len   = 2'd1;
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        byte0("bp_ef", 8'hEF, 1'b0, 1'b0);
        tick();
        out_ready = 1'b0;
        #1;
        byte0("bp_stall1", 8'hBE, 1'b1, 1'b0);
        tick();
        byte0("bp_stall2", 8'hBE, 1'b1, 1'b0);
        tick();
        out_ready = 1'b1;
        #1;
        byte0("bp_be", 8'hBE, 1'b1, 1'b1);
        tick();
        chk("bp_idle_valid", 32'(out_valid0), 32'd0);

        // MSB-first ordering on dut1
        in_word  = 32'h00A1B2C3;
        in_len   = 2'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        byte1("msb_b0", 8'hA1, 1'b0);
        tick();
        byte1("msb_b1", 8'hB2, 1'b0);
        tick();
        byte1("msb_b2", 8'hC3, 1'b1);
        tick();
        chk("msb_idle_valid", 32'(out_valid1), 32'd0);

        // reset in the middle of a word
        in_word  = 32'h12345678;
        in_len   = 2'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        byte0("mrst_b0", 8'h78, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready_low", 32'(in_ready0), 32'd0);
        tick();
        chk("mrst_valid", 32'(out_valid0), 32'd0);
        chk("mrst_byte", 32'(out_byte0), 32'h00);
        chk("mrst_in_ready", 32'(in_ready0), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mrst_rel_in_ready", 32'(in_ready0), 32'd1);
        tick();
        chk("mrst_no_stale", 32'(out_valid0), 32'd0);

        // new word offered during bytes 2-3 is taken only on the final byte
        in_word  = 32'h04030201;
        in_len   = 2'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        byte0("busy_b0", 8'h01, 1'b0, 1'b0);
        tick();
        in_word  = 32'h000000F5;
        in_len   = 2'd0;
        in_valid = 1'b1;
        #1;
        byte0("busy_b1", 8'h02, 1'b0, 1'b0);
        tick();
        byte0("busy_b2", 8'h03, 1'b0, 1'b0);
        tick();
        byte0("busy_b3", 8'h04, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        byte0("busy_f5", 8'hF5, 1'b1, 1'b1);
        tick();
        chk("busy_idle_valid", 32'(out_valid0), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/word_to_byte_serializer.md
Name: word_to_byte_serializer

Overview:
- Counterpart of the byte-merge path: takes a 32-bit word and streams it out one byte per accepted cycle.
- Byte order follows the merge convention: byte 0 is bits [7:0], byte 1 is bits [15:8], and so on.
- Feeds the byte-wide I/O and memory-store path of the DLX datapath.
- Valid/ready handshake on both sides; back-to-back words sustain 1 byte/cycle.

Parameters:
- MSB_FIRST, 0, 0 = emit byte 0 ([7:0]) first; 1 = emit the highest selected byte first.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_word  input  32  word to serialize.
- in_len  input  2  number of bytes minus 1 (0 = 1 byte … 3 = 4 bytes); the low-order bytes are selected.
- in_valid  input  1  in_word/in_len valid.
- in_ready  output  1  block can accept a word this cycle.
- out_byte  output  8  current byte.
- out_valid  output  1  out_byte valid.
- out_ready  input  1  consumer accepts out_byte.
- out_last  output  1  out_byte is the final byte of the current word.
- busy  output  1  word in progress (equals out_valid).

Behaviour:
- Reset, sampled at a clk edge with rst_n=0:
  - state=IDLE, out_valid=0, out_byte=8'h00, out_last=0, busy=0.
  - Internal word_q=0, len_q=0, cnt_q=0.
  - in_ready is forced 0 while rst_n=0.
- States:
  - IDLE: no word held.
  - SEND: word_q held; cnt_q (2 bits) indexes the next byte.
- in_ready is combinational: rst_n & (state==IDLE | (out_valid & out_ready & out_last)).
- Accept: in_valid & in_ready at edge t:
  - word_q<=in_word, len_q<=in_len, cnt_q<=0, state<=SEND.
  - Byte 0 of the sequence appears at t+1, giving latency 1 cycle.
- Byte select:
  - MSB_FIRST=0: index = cnt_q.
  - MSB_FIRST=1: index = len_q - cnt_q.
  - out_byte = word_q[8*index +: 8].
  - Bytes above len_q are never emitted.
- out_last = out_valid & (cnt_q==len_q).
- Advance: out_valid & out_ready & ~out_last sets cnt_q<=cnt_q+1. out_byte holds steady while out_ready=0.
- Final byte, out_valid & out_ready & out_last:
  - If in_valid=1: load the new word as in Accept and stay in SEND, with no bubble.
  - Otherwise: state<=IDLE, out_valid<=0.
- out_byte and out_last are registered or derived from registers only, with no combinational path from out_ready.
- Stability rules:
  - While out_valid=1 and out_ready=0, out_byte, out_last and the internal state hold.
  - In SEND, in_valid is ignored unless the final-byte handshake occurs in the same cycle.
  - in_word and in_len are sampled only on accept; changes at other times have no effect.
- Reset mid-word: the current word is discarded. Next cycle: IDLE, out_valid=0, no further bytes from the old word.
- cnt_q never wraps. The maximum value is 3 = len_q for a 4-byte word.

Test Plan:
- Reset, then word 32'hDDCCBBAA with len=3, out_ready held 1, MSB_FIRST=0:
  - Bytes AA, BB, CC, DD on 4 consecutive cycles starting 1 cycle after accept.
  - out_last=1 only with DD.
  - in_ready=1 on the DD cycle.
- Back-to-back: 32'h44332211 (len=3), then 32'h000000EE (len=0) held valid:
  - Stream 11, 22, 33, 44, EE with no idle cycle.
  - out_last on 44 and on EE.
  - Return to IDLE after EE when in_valid=0.
- Backpressure: 32'h0000BEEF with len=1; out_ready toggles 1,0,0,1:
  - EF is accepted, then BE is held stable for 2 stall cycles and accepted on the 4th cycle.
  - in_ready=0 during the stalls.
- MSB_FIRST=1, word 32'h00A1B2C3 with len=2: bytes A1, B2, C3; out_last with C3; byte 3 is never emitted.
- Reset mid-word: 32'h12345678 with len=3; assert rst_n=0 after byte 78 is accepted:
  - Next cycle out_valid=0, out_byte=00, in_ready=0.
  - After release, in_ready=1 and no stale 56 is emitted.
- in_valid while busy: present a second word during bytes 2–3 of the first with out_ready=1:
  - The second word is taken only on the final-byte cycle.
  - The first word's bytes are unaltered.
